// File: rtl/galaga_pkg.sv
// Shared constants and types for the Galaga CPU interrupt/control latch bank.
// Holds latch offsets, default line/width constants and a scanline-match helper.
package galaga_pkg;

    localparam logic [2:0]  OFS_IE0  = 3'd0;
    localparam logic [2:0]  OFS_IE1  = 3'd1;
    localparam logic [2:0]  OFS_NE2  = 3'd2;
    localparam logic [2:0]  OFS_SRST = 3'd3;

    localparam logic [15:0] LATCH_BASE_DEF = 16'h6820;
    localparam logic [8:0]  NMI_LINE0_DEF  = 9'd64;
    localparam logic [8:0]  NMI_LINE1_DEF  = 9'd192;
    localparam logic [7:0]  NMI_WIDTH_DEF  = 8'd64;

    typedef struct packed {
        logic ie0;
        logic ie1;
        logic ne2_n;
        logic srst_n;
    } latch_t;

    localparam latch_t LATCH_RESET = '{ie0: 1'b0, ie1: 1'b0, ne2_n: 1'b0, srst_n: 1'b0};

    function automatic logic is_nmi_line(input logic [8:0] v,
                                         input logic [8:0] l0,
                                         input logic [8:0] l1);
        return (v == l0) || (v == l1);
    endfunction

endpackage

// File: rtl/int_pulse.sv
// Reloadable down-counter pulse generator: trigger loads the width, kill zeroes it.
// The active output is registered and mirrors the post-edge count being nonzero.
module int_pulse #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         trig,
    input  logic         kill,
    input  logic [W-1:0] width,
    output logic         active
);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;

    // Next count: kill beats trigger, trigger retriggers, otherwise count down to 0 and hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (kill) begin
            cnt_nxt_s = {W{1'b0}};
        end else if (trig) begin
            cnt_nxt_s = width;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_nxt_s = cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and registered pulse output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {W{1'b0}};
            active <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            active <= (cnt_nxt_s != {W{1'b0}});
        end
    end

endmodule

// File: rtl/cpu_int_ctrl.sv
// Interrupt and sub-CPU control latch for the three-Z80 Galaga board.
// Decodes main-CPU latch writes and produces IRQ0/IRQ1 levels, the sound NMI pulse and SUBRST.
module cpu_int_ctrl
    import galaga_pkg::*;
#(
    parameter logic [15:0] LATCH_BASE = LATCH_BASE_DEF,
    parameter logic [8:0]  NMI_LINE0  = NMI_LINE0_DEF,
    parameter logic [8:0]  NMI_LINE1  = NMI_LINE1_DEF,
    parameter logic [7:0]  NMI_WIDTH  = NMI_WIDTH_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WR,
    input  logic [15:0] AD,
    input  logic [7:0]  DO,
    input  logic        VBLK,
    input  logic [8:0]  VCNT,
    output logic        IRQ0,
    output logic        IRQ1,
    output logic        NMI2,
    output logic        SUBRST
);

    latch_t     latch_r;
    latch_t     latch_nxt_s;
    logic       vblk_q;
    logic [8:0] vcnt_q;
    logic       irq0_r;
    logic       irq1_r;
    logic       subrst_r;
    logic       irq0_nxt_s;
    logic       irq1_nxt_s;
    logic       sel_s;
    logic       vb_rise_s;
    logic       line_hit_s;
    logic       nmi_kill_s;
    logic       unused_s;

    assign unused_s   = ^DO[7:1];
    assign sel_s      = WR && (AD[15:3] == LATCH_BASE[15:3]);
    assign vb_rise_s  = VBLK & ~vblk_q;
    assign line_hit_s = (VCNT != vcnt_q) & is_nmi_line(VCNT, NMI_LINE0, NMI_LINE1);

    // Latch write decode; a long WR simply rewrites the same value every cycle.
    always_comb begin
        latch_nxt_s = latch_r;
        if (sel_s) begin
            case (AD[2:0])
                OFS_IE0:  latch_nxt_s.ie0    = DO[0];
                OFS_IE1:  latch_nxt_s.ie1    = DO[0];
                OFS_NE2:  latch_nxt_s.ne2_n  = DO[0];
                OFS_SRST: latch_nxt_s.srst_n = DO[0];
                default:  latch_nxt_s        = latch_r;
            endcase
        end else begin
            latch_nxt_s = latch_r;
        end
    end

    // IRQ next state uses this cycle's written enables so a same-edge write wins over vb_rise.
    always_comb begin
        irq0_nxt_s = irq0_r;
        irq1_nxt_s = irq1_r;
        if (!latch_nxt_s.ie0) begin
            irq0_nxt_s = 1'b0;
        end else if (vb_rise_s) begin
            irq0_nxt_s = 1'b1;
        end else begin
            irq0_nxt_s = irq0_r;
        end
        if (!latch_nxt_s.ie1 || !latch_nxt_s.srst_n) begin
            irq1_nxt_s = 1'b0;
        end else if (vb_rise_s) begin
            irq1_nxt_s = 1'b1;
        end else begin
            irq1_nxt_s = irq1_r;
        end
    end

    assign nmi_kill_s = latch_nxt_s.ne2_n | ~latch_nxt_s.srst_n;

    // Latch bank, edge-detect history and registered interrupt outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            latch_r  <= LATCH_RESET;
            vblk_q   <= 1'b0;
            vcnt_q   <= 9'd0;
            irq0_r   <= 1'b0;
            irq1_r   <= 1'b0;
            subrst_r <= 1'b1;
        end else begin
            latch_r  <= latch_nxt_s;
            vblk_q   <= VBLK;
            vcnt_q   <= VCNT;
            irq0_r   <= irq0_nxt_s;
            irq1_r   <= irq1_nxt_s;
            subrst_r <= ~latch_nxt_s.srst_n;
        end
    end

    int_pulse #(.W(8)) u_nmi (
        .clk    (CLK),
        .rst    (RESET),
        .trig   (line_hit_s),
        .kill   (nmi_kill_s),
        .width  (NMI_WIDTH),
        .active (NMI2)
    );

    assign IRQ0   = irq0_r;
    assign IRQ1   = irq1_r;
    assign SUBRST = subrst_r;

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Self-checking bench for cpu_int_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural model.
module tb_cpu_int_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        WR = 1'b0;
    logic [15:0] AD = 16'h0000;
    logic [7:0]  DO = 8'h00;
    logic        VBLK = 1'b0;
    logic [8:0]  VCNT = 9'd0;
    logic        IRQ0, IRQ1, NMI2, SUBRST;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_int_ctrl dut (
        .CLK(CLK), .RESET(RESET), .WR(WR), .AD(AD), .DO(DO),
        .VBLK(VBLK), .VCNT(VCNT),
        .IRQ0(IRQ0), .IRQ1(IRQ1), .NMI2(NMI2), .SUBRST(SUBRST)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: plain flags plus the cycle on which the NMI pulse ends.
    int  cyc = 0;
    int  nmi_end = 0;
    bit  started = 0;
    bit  m_ie0, m_ie1, m_ne2n, m_srstn, m_irq0, m_irq1, m_vblk_prev;
    int  m_vcnt_prev;

    always @(posedge CLK) begin
        cyc++;
        started = 1;
        if (RESET) begin
            m_ie0 = 0; m_ie1 = 0; m_ne2n = 0; m_srstn = 0;
            m_irq0 = 0; m_irq1 = 0; m_vblk_prev = 0; m_vcnt_prev = 0;
            nmi_end = 0;
        end else begin
            bit rise, hit;
            if (WR && (AD >> 3) == (16'h6820 >> 3)) begin
                case (AD & 16'h7)
                    16'd0: m_ie0 = DO[0];
                    16'd1: m_ie1 = DO[0];
                    16'd2: m_ne2n = DO[0];
                    16'd3: m_srstn = DO[0];
                    default: ;
                endcase
            end
            rise = VBLK && !m_vblk_prev;
            hit  = (int'(VCNT) != m_vcnt_prev) && (VCNT == 9'd64 || VCNT == 9'd192);
            m_irq0 = m_ie0 ? (m_irq0 || rise) : 1'b0;
            m_irq1 = (m_ie1 && m_srstn) ? (m_irq1 || rise) : 1'b0;
            if (m_ne2n || !m_srstn) nmi_end = cyc;
            else if (hit) nmi_end = cyc + 64;
            m_vblk_prev = VBLK;
            m_vcnt_prev = int'(VCNT);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        if (started) begin
            check("model_irq0", IRQ0, m_irq0);
            check("model_irq1", IRQ1, m_irq1);
            check("model_nmi2", NMI2, cyc < nmi_end);
            check("model_subrst", SUBRST, !m_srstn);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic wr(input logic [15:0] a, input logic d);
        WR = 1'b1; AD = a; DO = {7'($urandom), d};
        step(3);
        WR = 1'b0; AD = 16'h0000;
    endtask

    task automatic count_nmi(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (NMI2) c++;
        end
    endtask

    int c;

    initial begin
        // Reset and idle.
        step(2);
        RESET = 1'b0;
        step(10);
        check("rst_subrst", SUBRST, 1'b1);
        check("rst_irq0", IRQ0, 1'b0);
        check("rst_irq1", IRQ1, 1'b0);
        check("rst_nmi2", NMI2, 1'b0);

        // Scanline sweep while sub CPUs held in reset: no NMI.
        c = 0;
        for (int v = 0; v < 264; v++) begin
            VCNT = 9'(v);
            @(negedge CLK);
            if (NMI2) c++;
        end
        check_int("sweep_no_nmi", c, 0);

        // IRQ0 on vblank, held, cleared by writing the enable to 0.
        wr(16'h6820, 1'b1);
        VBLK = 1'b1;
        step(2);
        check("irq0_vblank", IRQ0, 1'b1);
        step(100);
        check("irq0_held", IRQ0, 1'b1);
        VBLK = 1'b0;
        WR = 1'b1; AD = 16'h6820; DO = 8'h00;
        @(negedge CLK);
        check("irq0_clear", IRQ0, 1'b0);
        step(2);
        WR = 1'b0;

        // NMI pulses on both hit lines, static line fires once.
        wr(16'h6823, 1'b1);
        wr(16'h6822, 1'b0);
        check("subrst_release", SUBRST, 1'b0);
        VCNT = 9'd63; step(1);
        VCNT = 9'd64;
        count_nmi(100, c);
        check_int("nmi_width_line0", c, 64);
        VCNT = 9'd191; step(1);
        VCNT = 9'd192;
        count_nmi(100, c);
        check_int("nmi_width_line1", c, 64);
        VCNT = 9'd64;
        count_nmi(500, c);
        check_int("nmi_static_once", c, 64);

        // Truncate an active pulse by disabling the NMI.
        VCNT = 9'd63; step(1);
        VCNT = 9'd64; step(10);
        check("nmi_active", NMI2, 1'b1);
        WR = 1'b1; AD = 16'h6822; DO = 8'h01;
        @(negedge CLK);
        check("nmi_truncate", NMI2, 1'b0);
        step(2);
        WR = 1'b0;
        count_nmi(80, c);
        check_int("nmi_stays_off", c, 0);
        wr(16'h6822, 1'b0);

        // IRQ1 set, then forced low by sub-CPU reset.
        wr(16'h6821, 1'b1);
        VBLK = 1'b1; step(2);
        check("irq1_vblank", IRQ1, 1'b1);
        WR = 1'b1; AD = 16'h6823; DO = 8'h00;
        @(negedge CLK);
        check("srst_subrst", SUBRST, 1'b1);
        check("srst_irq1", IRQ1, 1'b0);
        step(2);
        WR = 1'b0;
        VBLK = 1'b0;

        // Same-edge cases.
        wr(16'h6823, 1'b1);
        step(1);
        VBLK = 1'b1;
        wr(16'h6821, 1'b0);
        check("same_edge_clr_irq1", IRQ1, 1'b0);
        VBLK = 1'b0;
        wr(16'h6820, 1'b0);
        step(1);
        VBLK = 1'b1;
        WR = 1'b1; AD = 16'h6820; DO = 8'h01;
        @(negedge CLK);
        check("same_edge_set_irq0", IRQ0, 1'b1);
        step(2);
        WR = 1'b0;

        // Unused offsets and out-of-bank address leave the latches alone.
        for (int a = 4; a < 9; a++) wr(16'h6820 + 16'(a), 1'b0);
        check("nofx_subrst", SUBRST, 1'b0);
        check("nofx_irq0", IRQ0, 1'b1);

        // Reset in the middle of a pulse with IRQ0 pending.
        VCNT = 9'd191; step(1);
        VCNT = 9'd192; step(5);
        check("pre_rst_nmi", NMI2, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        check("midrst_subrst", SUBRST, 1'b1);
        check("midrst_irq0", IRQ0, 1'b0);
        check("midrst_irq1", IRQ1, 1'b0);
        check("midrst_nmi2", NMI2, 1'b0);
        RESET = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            RESET = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) == 0) begin
                WR = 1'b1;
                AD = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                 : 16'h6820 + 16'($urandom_range(0, 15));
                DO = 8'($urandom);
                if (AD == 16'h6823 && $urandom_range(0, 3) != 0) DO[0] = 1'b1;
                if (AD == 16'h6822 && $urandom_range(0, 3) != 0) DO[0] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                WR = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) VBLK = ~VBLK;
            case ($urandom_range(0, 9))
                0: VCNT = 9'd63;
                1: VCNT = 9'd191;
                2, 3: VCNT = VCNT;
                default: VCNT = (VCNT >= 9'd263) ? 9'd0 : VCNT + 9'd1;
            endcase
            @(negedge CLK);
        end
        RESET = 1'b0; WR = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
